cook_program_controller: RTL

Parametrised multi-stage cook-programme controller; the next-generation timing/power core beneath the microwave top level. Holds a table of up to NUM_STAGES (seconds, power-level) entries and runs them in order from an internal 1 Hz prescaler. Produces a power-level PWM for the magnetron/motor driver, the live stage and remaining-time values for the FND path, and a done pulse plus timed alarm for the buzzer. Handles pause/resume, door interlock and cancel internally, replacing the single-timer, fixed-power scheme.

---
 rtl/cook_program_controller_if.sv | 34 +++
 rtl/cook_program_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cook_program_controller_if.sv
// Command, table-write and status bundle of the multi-stage cook-programme controller.
interface cook_program_controller_if #(
  parameter int IDX_W  = 2,
  parameter int TIME_W = 13,
  parameter int PWR_W  = 3
);
  logic              i_stage_wr;
  logic [IDX_W-1:0]  i_stage_idx;
  logic [TIME_W-1:0] i_stage_sec;
  logic [PWR_W-1:0]  i_stage_pwr;
  logic              i_start;
  logic              i_pause;
  logic              i_cancel;
  logic              i_door_open;
  logic [1:0]        o_state;
  logic [IDX_W-1:0]  o_stage;
  logic [TIME_W-1:0] o_remaining;
  logic              o_pwr_pwm;
  logic              o_done;
  logic              o_alarm;
  logic              o_err;

  modport master (
    output i_stage_wr, i_stage_idx, i_stage_sec, i_stage_pwr,
    output i_start, i_pause, i_cancel, i_door_open,
    input  o_state, o_stage, o_remaining, o_pwr_pwm, o_done, o_alarm, o_err
  );

  modport slave (
    input  i_stage_wr, i_stage_idx, i_stage_sec, i_stage_pwr,
    input  i_start, i_pause, i_cancel, i_door_open,
    output o_state, o_stage, o_remaining, o_pwr_pwm, o_done, o_alarm, o_err
  );
endinterface

// File: rtl/cook_program_controller.sv
// Multi-stage cook-programme controller: stage table, 1 Hz prescaler, power PWM and alarm.
// Optional COOK_DOOR_AUTORESUME_EN: a door-caused pause resumes when the door closes.
module cook_program_controller #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_STAGES = 4,
  parameter int TIME_W     = 13,
  parameter int MAX_SEC    = 5999,
  parameter int PWR_W      = 3,
  parameter int PWM_STEP   = 10_000,
  parameter int ALARM_SEC  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  cook_program_controller_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_STAGES);
  localparam int MAXLVL  = (1 << PWR_W) - 1;
  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int STEP_W  = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
  localparam int ALARM_W = $clog2(ALARM_SEC + 1);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);
  localparam logic [STEP_W-1:0]  STEP_TC  = STEP_W'(PWM_STEP - 1);
  localparam logic [PWR_W-1:0]   SLOT_TC  = PWR_W'(MAXLVL - 1);
  localparam logic [ALARM_W-1:0] ALARM_TC = ALARM_W'(ALARM_SEC - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TIME_W-1:0]  MAX_T    = TIME_W'(MAX_SEC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  logic [TIME_W-1:0]  sec_r [NUM_STAGES];
  logic [PWR_W-1:0]   pwr_r [NUM_STAGES];

  state_t             state_r, state_n;
  logic [IDX_W-1:0]   stage_r, stage_n;
  logic [TIME_W-1:0]  rem_r, rem_n;
  logic [PRESC_W-1:0] presc_r, presc_n;
  logic [STEP_W-1:0]  step_r, step_n;
  logic [PWR_W-1:0]   slot_r, slot_n;
  logic [PWR_W-1:0]   lvl_r, lvl_n;
  logic [ALARM_W-1:0] alarm_cnt_r, alarm_cnt_n;
  logic               door_pause_r, door_pause_n;
  logic               pwm_r, done_r, alarm_r, err_r;
  logic               done_n, err_n;

  logic               idle_like_s, tick_s, last_s, launch_s, end_s;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [TIME_W-1:0]  nxt_sec_s;

  assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign tick_s      = (presc_r == PRESC_TC);
  assign last_s      = (stage_r == LAST_IDX);
  assign nxt_idx_s   = stage_r + IDX_W'(1);
  assign nxt_sec_s   = last_s ? TIME_W'(0) : sec_r[nxt_idx_s];
  // The launch reads the table as it stood before any same-cycle write.
  assign launch_s    = idle_like_s && bus.i_start && !bus.i_door_open && (sec_r[0] != TIME_W'(0));
  assign end_s       = tick_s && (rem_r <= TIME_W'(1)) && (nxt_sec_s == TIME_W'(0));

  // Stage table: writes land only while no programme is active; seconds are clamped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sec_r[i] <= TIME_W'(0);
        pwr_r[i] <= PWR_W'(0);
      end
    end else if (bus.i_stage_wr && idle_like_s) begin
      sec_r[bus.i_stage_idx] <= (bus.i_stage_sec > MAX_T) ? MAX_T : bus.i_stage_sec;
      pwr_r[bus.i_stage_idx] <= bus.i_stage_pwr;
    end else begin
      sec_r <= sec_r;
      pwr_r <= pwr_r;
    end
  end

  // Next-state logic with priority cancel > door > pause > start.
  always_comb begin
    state_n      = state_r;
    stage_n      = stage_r;
    rem_n        = rem_r;
    presc_n      = presc_r;
    step_n       = step_r;
    slot_n       = slot_r;
    lvl_n        = lvl_r;
    alarm_cnt_n  = alarm_cnt_r;
    door_pause_n = door_pause_r;
    done_n       = 1'b0;
    err_n        = bus.i_stage_wr && !idle_like_s;
    if (bus.i_cancel) begin
      state_n      = ST_IDLE;
      stage_n      = IDX_W'(0);
      rem_n        = TIME_W'(0);
      presc_n      = PRESC_W'(0);
      alarm_cnt_n  = ALARM_W'(0);
      door_pause_n = 1'b0;
    end else if (launch_s) begin
      state_n      = ST_RUN;
      stage_n      = IDX_W'(0);
      rem_n        = sec_r[0];
      lvl_n        = pwr_r[0];
      presc_n      = PRESC_W'(0);
      step_n       = STEP_W'(0);
      slot_n       = PWR_W'(0);
      alarm_cnt_n  = ALARM_W'(0);
      door_pause_n = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: err_n = err_n | bus.i_start;
        ST_DONE: begin
          err_n = err_n | bus.i_start;
          if (tick_s) begin
            presc_n = PRESC_W'(0);
            if (alarm_cnt_r == ALARM_TC) begin
              state_n     = ST_IDLE;
              stage_n     = IDX_W'(0);
              alarm_cnt_n = ALARM_W'(0);
            end else begin
              alarm_cnt_n = alarm_cnt_r + ALARM_W'(1);
            end
          end else begin
            presc_n = presc_r + PRESC_W'(1);
          end
        end
        ST_RUN: begin
          step_n = (step_r == STEP_TC) ? STEP_W'(0) : step_r + STEP_W'(1);
          if (step_r == STEP_TC) begin
            slot_n = (slot_r == SLOT_TC) ? PWR_W'(0) : slot_r + PWR_W'(1);
          end else begin
            slot_n = slot_r;
          end
          presc_n = tick_s ? PRESC_W'(0) : presc_r + PRESC_W'(1);
          if (end_s) begin
            rem_n       = TIME_W'(0);
            done_n      = 1'b1;
            alarm_cnt_n = ALARM_W'(0);
          end else if (tick_s && (rem_r <= TIME_W'(1))) begin
            stage_n = nxt_idx_s;
            rem_n   = nxt_sec_s;
            lvl_n   = pwr_r[nxt_idx_s];
          end else if (tick_s) begin
            rem_n = rem_r - TIME_W'(1);
          end else begin
            rem_n = rem_r;
          end
          // A tick in the same cycle as pause/door is applied first; finishing beats pausing.
          if (end_s) begin
            state_n = ST_DONE;
          end else if (bus.i_door_open) begin
            state_n      = ST_PAUSED;
            door_pause_n = 1'b1;
          end else if (bus.i_pause) begin
            state_n      = ST_PAUSED;
            door_pause_n = 1'b0;
          end else begin
            state_n = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (bus.i_door_open) begin
            err_n = err_n | bus.i_start;
          end else if (bus.i_pause) begin
            door_pause_n = 1'b0;
          end else if (bus.i_start) begin
            state_n      = ST_RUN;
            door_pause_n = 1'b0;
`ifdef COOK_DOOR_AUTORESUME_EN
          end else if (door_pause_r) begin
            state_n      = ST_RUN;
            door_pause_n = 1'b0;
`endif
          end else begin
            state_n = ST_PAUSED;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      stage_r      <= IDX_W'(0);
      rem_r        <= TIME_W'(0);
      presc_r      <= PRESC_W'(0);
      step_r       <= STEP_W'(0);
      slot_r       <= PWR_W'(0);
      lvl_r        <= PWR_W'(0);
      alarm_cnt_r  <= ALARM_W'(0);
      door_pause_r <= 1'b0;
      pwm_r        <= 1'b0;
      done_r       <= 1'b0;
      alarm_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      stage_r      <= stage_n;
      rem_r        <= rem_n;
      presc_r      <= presc_n;
      step_r       <= step_n;
      slot_r       <= slot_n;
      lvl_r        <= lvl_n;
      alarm_cnt_r  <= alarm_cnt_n;
      door_pause_r <= door_pause_n;
      pwm_r        <= (state_n == ST_RUN) && (slot_n < lvl_n);
      done_r       <= done_n;
      alarm_r      <= (state_n == ST_DONE);
      err_r        <= err_n;
    end
  end

  assign bus.o_state     = state_r;
  assign bus.o_stage     = stage_r;
  assign bus.o_remaining = rem_r;
  assign bus.o_pwr_pwm   = pwm_r;
  assign bus.o_done      = done_r;
  assign bus.o_alarm     = alarm_r;
  assign bus.o_err       = err_r;
endmodule
